multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/opcode_decoder.sv | 62 ++++++
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state and instruction
// class enums, opcode match constants, pc_src/alu_op/imm_op/branch_op encodings
// and fault codes.
package ctrl_pkg;

    localparam int ALUOPSIZE = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
        CLS_B, CLS_BL, CLS_BCOND, CLS_CBZ, CLS_ILLEGAL
    } inst_class_e;

    // Opcode match constants; shorter ones are compared against the MSBs.
    localparam logic [10:0] OP_ADD   = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUBS  = 11'b111_0101_1000;
    localparam logic [10:0] OP_LSL   = 11'b110_1001_1011;
    localparam logic [9:0]  OP_ADDI  = 10'b100_1000_100;
    localparam logic [10:0] OP_LDUR  = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR  = 11'b111_1100_0000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'b0101_0100;
    localparam logic [7:0]  OP_CBZ   = 8'b1011_0100;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_BL  = 2'd2;

    localparam logic [ALUOPSIZE-1:0] ALU_NOP   = 4'd0;
    localparam logic [ALUOPSIZE-1:0] ALU_ADD   = 4'd2;
    localparam logic [ALUOPSIZE-1:0] ALU_LSL   = 4'd3;
    localparam logic [ALUOPSIZE-1:0] ALU_SUB   = 4'd6;
    localparam logic [ALUOPSIZE-1:0] ALU_PASSB = 4'd7;

    // Immediate extractor select, one-hot.
    localparam logic [4:0] IMM_NONE  = 5'b00000;
    localparam logic [4:0] IMM_I     = 5'b00001;
    localparam logic [4:0] IMM_D     = 5'b00010;
    localparam logic [4:0] IMM_B     = 5'b00100;
    localparam logic [4:0] IMM_CB    = 5'b01000;
    localparam logic [4:0] IMM_SHAMT = 5'b10000;

    localparam logic [5:0] BR_NONE   = 6'b000000;
    localparam logic [5:0] BR_UNCOND = 6'b000001;
    localparam logic [5:0] BR_LINK   = 6'b000010;
    localparam logic [5:0] BR_CBZ    = 6'b000100;
    // B.cond: tag in the top bits, the low opcode bits pass straight through.
    localparam logic [2:0] BR_COND_TAG = 3'b100;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier.
// Ports: opcode_i (11-bit opcode) -> class_o, alu_op_o, branch_op_o, imm_op_o.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = ALUOPSIZE
) (
    input  logic [10:0]        opcode_i,
    output inst_class_e        class_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [5:0]         branch_op_o,
    output logic [4:0]         imm_op_o
);

    always_comb begin
        class_o     = CLS_ILLEGAL;
        alu_op_o    = ALUOP_W'(ALU_NOP);
        branch_op_o = BR_NONE;
        imm_op_o    = IMM_NONE;
        if (opcode_i == OP_ADD) begin
            class_o  = CLS_R;
            alu_op_o = ALUOP_W'(ALU_ADD);
        end else if (opcode_i == OP_SUBS) begin
            class_o  = CLS_R;
            alu_op_o = ALUOP_W'(ALU_SUB);
        end else if (opcode_i == OP_LSL) begin
            class_o  = CLS_R;
            alu_op_o = ALUOP_W'(ALU_LSL);
            imm_op_o = IMM_SHAMT;
        end else if (opcode_i[10:1] == OP_ADDI) begin
            class_o  = CLS_I;
            alu_op_o = ALUOP_W'(ALU_ADD);
            imm_op_o = IMM_I;
        end else if (opcode_i == OP_LDUR) begin
            class_o  = CLS_LOAD;
            alu_op_o = ALUOP_W'(ALU_ADD);
            imm_op_o = IMM_D;
        end else if (opcode_i == OP_STUR) begin
            class_o  = CLS_STORE;
            alu_op_o = ALUOP_W'(ALU_ADD);
            imm_op_o = IMM_D;
        end else if (opcode_i[10:5] == OP_B) begin
            class_o     = CLS_B;
            imm_op_o    = IMM_B;
            branch_op_o = BR_UNCOND;
        end else if (opcode_i[10:5] == OP_BL) begin
            class_o     = CLS_BL;
            imm_op_o    = IMM_B;
            branch_op_o = BR_LINK;
        end else if (opcode_i[10:3] == OP_BCOND) begin
            class_o     = CLS_BCOND;
            imm_op_o    = IMM_CB;
            branch_op_o = {BR_COND_TAG, opcode_i[2:0]};
        end else if (opcode_i[10:3] == OP_CBZ) begin
            class_o     = CLS_CBZ;
            alu_op_o    = ALUOP_W'(ALU_PASSB);
            imm_op_o    = IMM_CB;
            branch_op_o = BR_CBZ;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait timeout, retire counter and
// sticky fault code.
// Ports: clk/rst (sync, active high); opcode, zero_flag, mem_ready in;
// ir_write, pc_write, pc_src, mem_req, mem_we, reg_write, link_write, alu_op,
// branch_op, imm_op, busy, retired, retired_cnt, fault out.
// OPCODE_W must be >= 11; the decoder looks at the top 11 bits.
//
// state  | meaning
// FETCH  | request instruction, load IR and PC+4 on mem_ready
// DECODE | classify opcode, illegal -> FAULT
// EXEC   | ALU/immediate select, branches resolve and retire here
// MEM    | data access, STORE retires here on mem_ready
// WB     | register file write, retire
// FAULT  | absorbing until rst, all strobes low
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = ALUOPSIZE,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_req,
    output logic                mem_we,
    output logic                reg_write,
    output logic                link_write,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [5:0]          branch_op,
    output logic [4:0]          imm_op,
    output logic                busy,
    output logic                retired,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [1:0]          fault
);

    ctrl_state_e        state_q, state_d;
    inst_class_e        class_q;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         fault_q, fault_d;
    logic               busy_q;

    inst_class_e        dec_class;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [5:0]         dec_branch_op;
    logic [4:0]         dec_imm_op;

    logic               mem_phase;
    logic               wait_hit;
    logic               retire;

    opcode_decoder #(.ALUOP_W(ALUOP_W)) u_dec (
        .opcode_i    (opcode[OPCODE_W-1 -: 11]),
        .class_o     (dec_class),
        .alu_op_o    (dec_alu_op),
        .branch_op_o (dec_branch_op),
        .imm_op_o    (dec_imm_op)
    );

    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
    // The counter reaches TIMEOUT this cycle; a simultaneous mem_ready wins.
    assign wait_hit  = mem_phase && !mem_ready && (wait_q == 8'(TIMEOUT - 1));
    assign wait_d    = (mem_phase && !mem_ready && !wait_hit) ? wait_q + 8'd1 : 8'd0;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_hit) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_class == CLS_ILLEGAL) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R, CLS_I:        state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (wait_hit) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_EXEC: retire = (class_q == CLS_B) || (class_q == CLS_BL) ||
                              (class_q == CLS_BCOND) || (class_q == CLS_CBZ);
            ST_MEM:  retire = mem_ready && (class_q == CLS_STORE);
            ST_WB:   retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_ILLEGAL;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
            fault_q <= FAULT_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_q + CNT_W'(retire);
            fault_q <= fault_d;
            // Only the very first FETCH after reset counts as idle.
            busy_q  <= busy_q | (state_d != ST_FETCH);
            if (state_q == ST_DECODE) begin
                class_q <= dec_class;
            end
        end
    end

    // Strobes decode the registered state; rst blanks them in its own cycle
    // because the synchronous reset has not taken effect on state_q yet.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        link_write = 1'b0;
        alu_op     = ALUOP_W'(ALU_NOP);
        branch_op  = BR_NONE;
        imm_op     = IMM_NONE;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_op    = dec_alu_op;
                    imm_op    = dec_imm_op;
                    branch_op = dec_branch_op;
                    case (class_q)
                        CLS_B: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BR;
                        end
                        CLS_BL: begin
                            pc_write   = 1'b1;
                            pc_src     = PC_SRC_BL;
                            link_write = 1'b1;
                        end
                        // The datapath gates this write with the branch_op condition.
                        CLS_BCOND: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BR;
                        end
                        CLS_CBZ: begin
                            pc_write = zero_flag;
                            pc_src   = PC_SRC_BR;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CLS_STORE);
                end
                ST_WB:   reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired     = retire && !rst;
    assign retired_cnt = cnt_q;
    assign fault       = fault_q;
    assign busy        = !rst && (busy_q || (state_q != ST_FETCH));

endmodule
